// File: rtl/mem_req_bridge_pkg.sv
// MemBridgePkg: shared definitions for the CPU-to-memory request bridge.
//   state_t       - bridge FSM states (IDLE / WAIT / DONE)
//   MMIO_*_OFS    - byte offsets of the on-bridge registers from the MMIO base
//   ERR_PATTERN   - read data returned for aborted or misaligned accesses
package MemBridgePkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] MMIO_DBG_OFS = 32'h0000_0000;
  localparam logic [31:0] MMIO_CYC_OFS = 32'h0000_0004;
  localparam logic [31:0] ERR_PATTERN  = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_req_bridge_mmio_regs.sv
// mmio_regs: on-bridge register window.
//   clk, reset - clock, asynchronous active-high reset
//   wr_en      - one-cycle write strobe for the access at 'offset'
//   offset     - byte offset from the MMIO base
//   wdata      - write data
//   rdata      - combinational read data for 'offset'
//   dbg_out    - debug register (offset 0, R/W)
// Offset 4 is a free-running cycle counter (read-only); every other offset
// reads 0 and ignores writes.
module mmio_regs
  import MemBridgePkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] offset,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] dbg_out
);

  logic [31:0] cycle_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbg_out   <= 32'd0;
      cycle_cnt <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (wr_en && (offset == MMIO_DBG_OFS)) begin
        dbg_out <= wdata;
      end
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (offset == MMIO_DBG_OFS) begin
      rdata = dbg_out;
    end else if (offset == MMIO_CYC_OFS) begin
      rdata = cycle_cnt;
    end
  end

endmodule

// File: rtl/mem_req_bridge.sv
// mem_req_bridge: turns a stalling CPU request interface into a level
// request / pulse acknowledge memory interface, with an on-bridge MMIO window.
//   clk, reset            - clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata - CPU access, held until cpu_stall is low
//   cpu_rdata, cpu_stall  - load data (valid when stall low), freeze request
//   mem_req/we/addr/wdata - memory request, held stable while in WAIT
//   mem_ack, mem_rdata    - memory completion pulse and load data
//   dbg_out               - MMIO debug register
//   bus_err               - sticky error (timeout or misaligned access)
// Handshake: a CPU access completes in the first cycle where cpu_req is high
// and cpu_stall is low; a memory access completes in the cycle mem_ack is high
// while mem_req is high. mem_ack at any other time is ignored.
module mem_req_bridge
  import MemBridgePkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] MMIO_BASE      = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] dbg_out,
  output logic        bus_err
);

  // The timeout fires in the WAIT cycle whose increment would bring the
  // counter to TIMEOUT_CYCLES, so exactly TIMEOUT_CYCLES WAIT cycles elapse.
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] tmo_cnt;
  logic [31:0] rd_reg;
  logic [31:0] mmio_rdata;

  logic is_mmio, idle_req, mmio_hit, mmio_wr, start, misal, ack_hit, tmo_hit;

  always_comb begin
    is_mmio  = (cpu_addr >= MMIO_BASE);
    idle_req = (state == IDLE) && cpu_req && !reset;
    mmio_hit = idle_req && is_mmio;
    mmio_wr  = mmio_hit && cpu_we;
    start    = idle_req && !is_mmio && (cpu_addr[1:0] == 2'b00);
    misal    = idle_req && !is_mmio && (cpu_addr[1:0] != 2'b00);
    ack_hit  = (state == WAIT) && mem_ack;
    tmo_hit  = (state == WAIT) && !mem_ack && (tmo_cnt == TMO_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cpu_stall = 1'b0;
    cpu_rdata = 32'd0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    case (state)
      IDLE: begin
        if (start) begin
          cpu_stall = 1'b1;
          state_nxt = WAIT;
        end else if (misal) begin
          cpu_stall = 1'b1;
          state_nxt = DONE;
        end else if (mmio_hit) begin
          cpu_rdata = mmio_rdata;
        end
      end
      WAIT: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        mem_we    = lat_we;
        if (ack_hit || tmo_hit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        cpu_rdata = rd_reg;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      tmo_cnt   <= 32'd0;
      rd_reg    <= 32'd0;
      bus_err   <= 1'b0;
    end else begin
      if (start) begin
        lat_we    <= cpu_we;
        lat_addr  <= cpu_addr;
        lat_wdata <= cpu_wdata;
        tmo_cnt   <= 32'd0;
      end else if ((state == WAIT) && !mem_ack) begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end
      if (ack_hit && !lat_we) begin
        rd_reg <= mem_rdata;
      end
      if (tmo_hit || misal) begin
        rd_reg  <= ERR_PATTERN;
        bus_err <= 1'b1;
      end
    end
  end

  mmio_regs u_mmio_regs (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (mmio_wr),
    .offset  (cpu_addr - MMIO_BASE),
    .wdata   (cpu_wdata),
    .rdata   (mmio_rdata),
    .dbg_out (dbg_out)
  );

endmodule

// File: tb/tb_mem_req_bridge.sv
// tb_mem_req_bridge: directed and randomized checks of mem_req_bridge with a
// short timeout. The reference model works at transaction level: each access
// predicts its stall count, memory-request cycle count, read data and error
// flag from the access kind and the memory's acknowledge delay.
module tb_mem_req_bridge;

  localparam int          T   = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  localparam logic [31:0] MB  = 32'hFFFF_0000;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] dbg_out;
  logic        bus_err;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic        exp_err;
  logic [31:0] dbg_model;
  logic [31:0] mem_model [bit [31:0]];
  logic [31:0] exp_q[$];

  mem_req_bridge #(.TIMEOUT_CYCLES(T), .MMIO_BASE(MB)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .dbg_out   (dbg_out),
    .bus_err   (bus_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: one CPU access from posedge+1 until the cycle stall is low;
  // also plays the memory, acking in the delay-th mem_req cycle.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input int delay, input logic [31:0] mval,
                        output logic [31:0] rdata, output int stalls, output int mreq,
                        output logic mem_ok, output logic done);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    stalls = 0; mreq = 0; mem_ok = 1'b1; done = 1'b0; rdata = 32'd0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        mreq++;
        if (mem_addr !== addr || mem_we !== we || (we && mem_wdata !== wd)) mem_ok = 1'b0;
        if (mreq == delay) begin
          mem_ack = 1'b1;
          mem_rdata = mval;
        end
      end
      if (cpu_stall === 1'b0) begin
        rdata = cpu_rdata;
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      mem_rdata = $urandom;
    end
    cpu_req = 1'b0;
  endtask

  // memory-range access with scoreboard prediction
  task automatic run_mem(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input int delay);
    logic [31:0] mval, rd;
    int st, mr, w;
    logic ok, dn;
    bit mis, to;
    mis = (addr[1:0] != 2'b00);
    to  = !mis && (delay > T);
    w   = mis ? 0 : (to ? T : delay);
    mval = $urandom;
    if (!mis && !we) begin
      if (!mem_model.exists(addr)) mem_model[addr] = $urandom;
      mval = mem_model[addr];
    end
    if (!we) exp_q.push_back((mis || to) ? ERR : mval);
    if (we && !mis && !to) mem_model[addr] = wd;
    if (mis || to) exp_err = 1'b1;
    access(we, addr, wd, delay, mval, rd, st, mr, ok, dn);
    check({tag, ":done"}, 32'(dn), 32'd1);
    check({tag, ":stalls"}, 32'(st), 32'(mis ? 1 : 1 + w));
    check({tag, ":mreq_cycles"}, 32'(mr), 32'(w));
    check({tag, ":mem_stable"}, 32'(ok), 32'd1);
    if (!we) check({tag, ":rdata"}, rd, exp_q.pop_front());
    check({tag, ":bus_err"}, 32'(bus_err), 32'(exp_err));
  endtask

  // MMIO access; returns read data for the caller
  task automatic run_mmio(input string tag, input logic we, input logic [31:0] ofs,
                          input logic [31:0] wd, output logic [31:0] rd);
    int st, mr;
    logic ok, dn;
    access(we, MB + ofs, wd, 1, 32'd0, rd, st, mr, ok, dn);
    if (we && ofs == 32'd0) dbg_model = wd;
    check({tag, ":done"}, 32'(dn), 32'd1);
    check({tag, ":stalls"}, 32'(st), 32'd0);
    check({tag, ":mreq_cycles"}, 32'(mr), 32'd0);
    check({tag, ":dbg_out"}, dbg_out, dbg_model);
    if (!we && ofs != 32'd4) check({tag, ":rdata"}, rd, (ofs == 32'd0) ? dbg_model : 32'd0);
  endtask

  initial begin
    logic [31:0] rd, c0, c1, c2, c3;
    int gap;
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0; exp_err = 1'b0; dbg_model = 32'd0;

    #2;
    check("rst:mem_req", 32'(mem_req), 32'd0);
    check("rst:cpu_stall", 32'(cpu_stall), 32'd0);
    check("rst:mem_addr", mem_addr, 32'd0);
    check("rst:cpu_rdata", cpu_rdata, 32'd0);
    check("rst:dbg_out", dbg_out, 32'd0);
    check("rst:bus_err", 32'(bus_err), 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // directed memory accesses
    mem_model[32'h10] = 32'h1234_5678;
    run_mem("load_ack3", 1'b0, 32'h10, 32'd0, 3);
    run_mem("store_cafe", 1'b1, 32'h20, 32'hCAFE_F00D, 2);
    run_mem("load_back", 1'b0, 32'h20, 32'd0, 1);
    run_mem("ack_at_tmo", 1'b0, 32'h30, 32'd0, T);

    // MMIO window
    run_mmio("mmio_wr_dbg", 1'b1, 32'd0, 32'hA5, rd);
    run_mmio("mmio_rd_dbg", 1'b0, 32'd0, 32'd0, rd);
    run_mmio("cyc_a", 1'b0, 32'd4, 32'd0, c0);
    run_mmio("cyc_b", 1'b0, 32'd4, 32'd0, c1);
    check("cyc_back_to_back", c1 - c0, 32'd1);
    gap = $urandom_range(1, 5);
    repeat (gap) @(posedge clk);
    #1;
    run_mmio("cyc_c", 1'b0, 32'd4, 32'd0, c2);
    check("cyc_gap", c2 - c1, 32'(gap + 1));
    run_mmio("cyc_wr_ignored", 1'b1, 32'd4, 32'd0, rd);
    run_mmio("cyc_d", 1'b0, 32'd4, 32'd0, c3);
    check("cyc_after_wr", c3 - c2, 32'd2);
    run_mmio("ofs8_wr", 1'b1, 32'd8, 32'hFFFF_FFFF, rd);
    run_mmio("ofs8_rd", 1'b0, 32'd8, 32'd0, rd);

    // misaligned memory access
    run_mem("misalign", 1'b0, 32'h2, 32'd0, 1);

    // randomized mix
    for (int i = 0; i < 20; i++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind <= 5)
        run_mem("rand_mem", 1'($urandom_range(0, 1)), 32'h100 + 32'(4 * $urandom_range(0, 7)),
                $urandom, $urandom_range(1, 6));
      else if (kind == 6)
        run_mem("rand_misal", 1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(1, 3)),
                $urandom, 1);
      else if (kind == 7)
        run_mmio("rand_dbg_wr", 1'b1, 32'd0, $urandom, rd);
      else if (kind == 8)
        run_mmio("rand_dbg_rd", 1'b0, 32'd0, 32'd0, rd);
      else
        run_mmio("rand_ofs12", 1'b0, 32'd12, 32'd0, rd);
    end

    // reset in the middle of WAIT, then a stray ack
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    @(posedge clk); #1;
    @(negedge clk);
    check("midwait:mem_req", 32'(mem_req), 32'd1);
    #2;
    reset = 1'b1; cpu_req = 1'b0;
    exp_err = 1'b0; dbg_model = 32'd0;
    #1;
    check("midwait_rst:mem_req", 32'(mem_req), 32'd0);
    check("midwait_rst:mem_we", 32'(mem_we), 32'd0);
    check("midwait_rst:mem_addr", mem_addr, 32'd0);
    check("midwait_rst:mem_wdata", mem_wdata, 32'd0);
    check("midwait_rst:cpu_stall", 32'(cpu_stall), 32'd0);
    check("midwait_rst:cpu_rdata", cpu_rdata, 32'd0);
    check("midwait_rst:dbg_out", dbg_out, 32'd0);
    check("midwait_rst:bus_err", 32'(bus_err), 32'd0);
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    check("stray_ack:mem_req", 32'(mem_req), 32'd0);
    check("stray_ack:cpu_stall", 32'(cpu_stall), 32'd0);
    check("stray_ack:cpu_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("stray_ack_after:mem_req", 32'(mem_req), 32'd0);
    run_mmio("cyc_after_rst", 1'b0, 32'd4, 32'd0, c0);
    check("cyc_after_rst:value", c0, 32'd2);

    // timeout, then bus_err stays set through a good access
    run_mem("timeout", 1'b0, 32'h50, 32'd0, 100);
    run_mem("good_after_err", 1'b1, 32'h54, 32'h0BAD_F00D, 2);
    run_mem("good_load_after_err", 1'b0, 32'h54, 32'd0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed still running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/mem_req_bridge.md
MEM_REQ_BRIDGE -- requirements
Module: mem_req_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of WAIT cycles before a memory access is aborted.
REQ-002 SHALL have parameter MMIO_BASE, default 32'hFFFF_0000, meaning the base of the on-bridge register window; addresses at or above it never reach memory.
REQ-003 SHALL have ports (one clock; reset is asynchronous and active-high):
 clk        in   1   sole clock, rising edge
 reset      in   1   asynchronous, active-high reset
 cpu_req    in   1   CPU access request, level, held until cpu_stall low
 cpu_we     in   1   1=store, 0=load
 cpu_addr   in   32  byte address
 cpu_wdata  in   32  store data
 cpu_rdata  out  32  load data, valid in the cycle cpu_stall is low with cpu_req high
 cpu_stall  out  1   CPU must freeze all state-update enables while high
 mem_req    out  1   memory request, level
 mem_we     out  1   memory write enable, qualified by mem_req
 mem_addr   out  32  word-aligned memory address
 mem_wdata  out  32  memory write data
 mem_ack    in   1   memory completion, 1-cycle pulse
 mem_rdata  in   32  read data, valid with mem_ack
 dbg_out    out  32  MMIO debug register
 bus_err    out  1   sticky error flag

Function
REQ-004 SHALL implement FSM states IDLE, WAIT, DONE; the state register, the request latch and the timeout counter SHALL be flops.
REQ-005 In IDLE, a cpu_req to an address below MMIO_BASE with addr[1:0]==0 SHALL latch cpu_addr, cpu_we and cpu_wdata, clear the timeout counter, and move to WAIT; cpu_stall SHALL be 1 combinationally in that cycle.
REQ-006 In WAIT, mem_req SHALL be 1, and mem_we, mem_addr and mem_wdata SHALL be driven from the latch, stable until exit; cpu_stall SHALL be 1.
REQ-007 In WAIT, mem_ack=1 SHALL capture mem_rdata (loads only) into the read register and move to DONE.
REQ-008 In WAIT, each cycle without mem_ack SHALL increment the counter; when the counter reaches TIMEOUT_CYCLES, the FSM SHALL move to DONE, set bus_err, and load 32'hDEAD_BEEF into the read register.
REQ-009 If mem_ack and timeout occur in the same cycle, mem_ack SHALL win and bus_err SHALL NOT be set.
REQ-010 In DONE, cpu_stall SHALL be 0, cpu_rdata SHALL be the read register, mem_req SHALL be 0, and the next state SHALL be IDLE unconditionally; the held cpu_req SHALL NOT start a new access.
REQ-011 A misaligned request (addr[1:0]!=0) to the memory range SHALL be a WAIT-free error: no mem_req, bus_err set, move to DONE with read register = 32'hDEAD_BEEF.
REQ-012 An MMIO access SHALL complete in zero wait cycles from IDLE: cpu_stall=0, the FSM stays in IDLE, and no mem_req is issued.
REQ-013 The MMIO map SHALL be: MMIO_BASE+0 dbg_out (R/W); MMIO_BASE+4 free-running 32-bit cycle counter (RO, wraps at 2^32, writes ignored); all other MMIO offsets read 0 and ignore writes.
REQ-014 An MMIO write SHALL update dbg_out at the clock edge ending the request cycle; an MMIO read SHALL drive cpu_rdata combinationally.
REQ-015 mem_ack received in IDLE or DONE SHALL be ignored.
REQ-016 bus_err SHALL be sticky and cleared only by reset.
REQ-017 In IDLE with cpu_req=0, cpu_stall SHALL be 0 and cpu_rdata SHALL be 0.

Reset
REQ-018 On reset assertion, asynchronously: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, read register=0, dbg_out=0, cycle counter=0, timeout counter=0, bus_err=0, cpu_stall=0.
REQ-019 Reset asserted in WAIT SHALL drop mem_req immediately, and a later mem_ack for the aborted access SHALL be ignored.

Structure
REQ-020 The state enum (IDLE/WAIT/DONE), the MMIO offsets, and the error pattern 32'hDEAD_BEEF SHALL live in a shared package MemBridgePkg.
REQ-021 The MMIO register file SHALL be one sub-module, mmio_regs (dbg_out plus cycle counter, read mux), instantiated by mem_req_bridge.

Verification
REQ-022 Load at 0x0000_0010, memory acks after 3 cycles with 0x1234_5678 -> cpu_stall high for 4 cycles, then one cycle stall=0 with cpu_rdata=0x1234_5678.
REQ-023 Store 0xCAFE_F00D to 0x0000_0020 -> mem_req/mem_we=1, mem_addr=0x20, mem_wdata=0xCAFEF00D stable until ack; bus_err stays 0.
REQ-024 Load with no mem_ack, TIMEOUT_CYCLES=4 -> mem_req drops after 4 WAIT cycles, cpu_rdata=0xDEADBEEF, bus_err=1 and stays 1 for subsequent good accesses.
REQ-025 Store 0xA5 to 0xFFFF_0000, then load 0xFFFF_0000 -> no stall, no mem_req, dbg_out=0xA5, cpu_rdata=0xA5; load 0xFFFF_0004 on two consecutive requests -> values differ by the elapsed cycle count.
REQ-026 Load at 0x0000_0002 -> no mem_req, one stall cycle, cpu_rdata=0xDEADBEEF, bus_err=1.
REQ-027 Reset asserted mid-WAIT, then stray mem_ack -> mem_req=0 immediately, state IDLE, ack ignored, all outputs at reset values.
